// File: rtl/rv32m_pkg.sv
// Shared RV32M definitions: FUNC3 encodings for the divide group and the
// divider state type, plus a small magnitude helper used at operand capture.
package rv32m_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN
    } div_state_t;

    // Absolute value for signed ops; 0x80000000 maps to itself, which is the
    // correct unsigned magnitude.
    function automatic logic [XLEN-1:0] mag32(input logic [XLEN-1:0] v,
                                              input logic            is_signed);
        return (is_signed && v[XLEN-1]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract the divisor, keep or restore, and report the quotient bit.
module div_step
    import rv32m_pkg::*;
(
    input  logic [XLEN:0]   rem_in,
    input  logic [XLEN-1:0] divisor,
    input  logic            dvd_bit,
    output logic [XLEN:0]   rem_out,
    output logic            q_bit
);

    logic [XLEN+1:0] diff;

    always_comb begin
        diff    = {rem_in, dvd_bit} - {2'b00, divisor};
        q_bit   = ~diff[XLEN+1];
        rem_out = q_bit ? diff[XLEN:0] : {rem_in[XLEN-1:0], dvd_bit};
    end

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M divide/remainder unit with a START/BUSY/DONE handshake.
// One quotient bit per CALC cycle; divide-by-zero and signed overflow bypass to FIN.
module div_unit
    import rv32m_pkg::*;
(
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [XLEN-1:0] IN0,
    input  logic [XLEN-1:0] IN1,
    input  logic [2:0]      FUNC3,
    output logic            BUSY,
    output logic            DONE,
    output logic [XLEN-1:0] OUT
);

    div_state_t state, next_state;

    logic [5:0]      count;
    logic [XLEN:0]   rem;
    logic [XLEN-1:0] dvd;
    logic [XLEN-1:0] dvsr;
    logic [XLEN-1:0] out_r;
    logic            neg_q;
    logic            neg_r;
    logic            sel_rem;

    logic [XLEN:0]   step_rem;
    logic            step_q;

    logic            op_valid;
    logic            op_signed;
    logic            op_rem;
    logic            div_zero;
    logic            overflow;
    logic            special;
    logic            accept;
    logic            last_iter;
    logic [XLEN-1:0] special_res;
    logic [XLEN-1:0] final_q;
    logic [XLEN-1:0] final_r;
    logic [XLEN-1:0] calc_res;

    div_step u_step (
        .rem_in  (rem),
        .divisor (dvsr),
        .dvd_bit (dvd[XLEN-1]),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_comb begin
        op_valid  = FUNC3[2];
        op_signed = (FUNC3 == F3_DIV) || (FUNC3 == F3_REM);
        op_rem    = (FUNC3 == F3_REM) || (FUNC3 == F3_REMU);
        div_zero  = (IN1 == '0);
        overflow  = op_signed && (IN0 == 32'h8000_0000) && (IN1 == '1);
        special   = div_zero || overflow;
        accept    = (state == IDLE) && START && op_valid;
        last_iter = (state == CALC) && (count == 6'd31);

        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = special ? FIN : CALC;
            CALC:    if (last_iter) next_state = FIN;
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The final quotient/remainder are taken from the step outputs of the
    // last iteration so OUT can be loaded on the same edge that enters FIN.
    always_comb begin
        if (div_zero) special_res = op_rem ? IN0 : '1;
        else          special_res = op_rem ? '0 : 32'h8000_0000;

        final_q  = {dvd[XLEN-2:0], step_q};
        final_r  = step_rem[XLEN-1:0];
        calc_res = sel_rem ? (neg_r ? (~final_r + 32'd1) : final_r)
                           : (neg_q ? (~final_q + 32'd1) : final_q);
    end

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= next_state;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            count   <= '0;
            rem     <= '0;
            dvd     <= '0;
            dvsr    <= '0;
            out_r   <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            sel_rem <= 1'b0;
        end else if (accept) begin
            count   <= '0;
            rem     <= '0;
            dvd     <= mag32(IN0, op_signed);
            dvsr    <= mag32(IN1, op_signed);
            neg_q   <= op_signed && (IN0[XLEN-1] ^ IN1[XLEN-1]);
            neg_r   <= op_signed && IN0[XLEN-1];
            sel_rem <= op_rem;
            if (special) out_r <= special_res;
        end else if (state == CALC) begin
            rem <= step_rem;
            dvd <= {dvd[XLEN-2:0], step_q};
            if (last_iter) out_r <= calc_res;
            else           count <= count + 6'd1;
        end
    end

    always_comb begin
        BUSY = (state == CALC);
        DONE = (state == FIN);
        OUT  = out_r;
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, hand-written
// handshake/reset sequences, and randomized ops against an arithmetic model.
module tb_div_unit;
    import rv32m_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        START;
    logic [31:0] IN0;
    logic [31:0] IN1;
    logic [2:0]  FUNC3;
    logic        BUSY;
    logic        DONE;
    logic [31:0] OUT;

    int n_checks = 0;
    int n_fail   = 0;

    div_unit dut (
        .CLK   (CLK),
        .RESET (RESET),
        .START (START),
        .IN0   (IN0),
        .IN1   (IN1),
        .FUNC3 (FUNC3),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .OUT   (OUT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_out;
        int          exp_lat;
    } vec_t;

    vec_t vecs[12];

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Reference: plain 64-bit arithmetic, with RV32M divide-by-zero rules.
    function automatic logic [31:0] ref_div(input logic [2:0] f3,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        logic   sgn;
        sgn = ~f3[0];
        if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
        sa = sgn ? longint'({{32{a[31]}}, a}) : longint'({32'd0, a});
        sb = sgn ? longint'({{32{b[31]}}, b}) : longint'({32'd0, b});
        q  = sa / sb;
        r  = sa % sb;
        return f3[1] ? 32'(r) : 32'(q);
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic do_op(input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_out,
                         input int exp_lat, input string name);
        int lat, busy_cnt;
        @(negedge CLK);
        FUNC3 = f3; IN0 = a; IN1 = b; START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        IN0 = $urandom; IN1 = $urandom;
        lat = 0; busy_cnt = 0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(negedge CLK);
            if (BUSY) busy_cnt++;
            if (DONE) lat = c;
        end
        check({name, " latency"}, lat, exp_lat);
        check({name, " out"}, OUT, exp_out);
        check({name, " busy cycles"}, busy_cnt, (exp_lat == 1) ? 0 : 32);
        @(negedge CLK);
        check({name, " done pulse"}, {31'd0, DONE}, 32'd0);
        check({name, " out hold"}, OUT, exp_out);
    endtask

    initial begin
        int lat, dones;
        logic [2:0]  f3;
        logic [31:0] a, b;

        vecs[0]  = '{F3_DIV,  32'd100,        32'd7,          32'd14,         33};
        vecs[1]  = '{F3_REM,  32'd100,        32'd7,          32'd2,          33};
        vecs[2]  = '{F3_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33};
        vecs[3]  = '{F3_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33};
        vecs[4]  = '{F3_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33};
        vecs[5]  = '{F3_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
        vecs[6]  = '{F3_REMU, 32'd5,          32'd0,          32'd5,          1};
        vecs[7]  = '{F3_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
        vecs[8]  = '{F3_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
        vecs[9]  = '{F3_REMU, 32'd100,        32'd7,          32'd2,          33};
        vecs[10] = '{F3_DIV,  32'd7,          32'd0,          32'hFFFF_FFFF,  1};
        vecs[11] = '{F3_REM,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  1};

        RESET = 1'b1; START = 1'b0; IN0 = '0; IN1 = '0; FUNC3 = '0;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        check("reset busy", {31'd0, BUSY}, 32'd0);
        check("reset done", {31'd0, DONE}, 32'd0);
        check("reset out", OUT, 32'd0);

        foreach (vecs[i])
            do_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp_out,
                  vecs[i].exp_lat, $sformatf("vec%0d", i));

        // Second START while busy must not disturb the running operation.
        @(negedge CLK);
        FUNC3 = F3_DIV; IN0 = 32'd100; IN1 = 32'd7; START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        lat = 0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(negedge CLK);
            if (DONE) lat = c;
            if (c == 10) begin
                FUNC3 = F3_DIVU; IN0 = 32'd9; IN1 = 32'd3; START = 1'b1;
            end else begin
                START = 1'b0;
            end
        end
        START = 1'b0;
        check("busy start latency", lat, 33);
        check("busy start out", OUT, 32'd14);

        // START coincident with DONE is ignored (a divide-by-zero would finish next cycle).
        @(negedge CLK);
        FUNC3 = F3_DIVU; IN0 = 32'd1000; IN1 = 32'd10; START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        lat = 0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(negedge CLK);
            if (DONE) begin
                lat = c;
                FUNC3 = F3_DIVU; IN0 = 32'd7; IN1 = 32'd0; START = 1'b1;
            end
        end
        @(posedge CLK);
        #1;
        START = 1'b0;
        check("done start latency", lat, 33);
        @(negedge CLK);
        check("done start ignored done", {31'd0, DONE}, 32'd0);
        check("done start ignored busy", {31'd0, BUSY}, 32'd0);
        check("done start out", OUT, 32'd100);

        // RESET mid-operation aborts with no DONE.
        @(negedge CLK);
        FUNC3 = F3_DIV; IN0 = 32'd100; IN1 = 32'd7; START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        for (int c = 1; c <= 15; c++) @(negedge CLK);
        check("pre-abort busy", {31'd0, BUSY}, 32'd1);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        check("abort busy", {31'd0, BUSY}, 32'd0);
        check("abort out", OUT, 32'd0);
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            if (DONE) dones++;
            @(negedge CLK);
        end
        check("abort no done", dones, 0);
        do_op(F3_DIVU, 32'd9, 32'd3, 32'd3, 33, "after abort");

        // RESET wins over START in the same cycle.
        @(negedge CLK);
        RESET = 1'b1; START = 1'b1; FUNC3 = F3_DIVU; IN0 = 32'd5; IN1 = 32'd0;
        @(posedge CLK);
        #1;
        RESET = 1'b0; START = 1'b0;
        @(negedge CLK);
        check("reset+start done", {31'd0, DONE}, 32'd0);
        check("reset+start out", OUT, 32'd0);
        @(negedge CLK);
        check("reset+start done2", {31'd0, DONE}, 32'd0);

        // FUNC3 0xx is not a divide op.
        @(negedge CLK);
        FUNC3 = 3'b011; IN0 = 32'd5; IN1 = 32'd0; START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        dones = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            if (DONE || BUSY) dones++;
        end
        check("invalid func3 activity", dones, 0);
        check("invalid func3 out", OUT, 32'd0);

        for (int i = 0; i < 150; i++) begin
            f3 = 3'b100 | 3'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: b = 32'hFFFF_FFFF;
                4: a = 32'h8000_0000;
                default: ;
            endcase
            do_op(f3, a, b, ref_div(f3, a, b), ref_lat(f3, a, b),
                  $sformatf("rand%0d f3=%b a=%h b=%h", i, f3, a, b));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
